// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32I pipeline: bubble instruction, reset PC,
// PC alignment mask and the IF/ID pipeline-register bundle.
package rv_pipe_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST      = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] RESET_PC      = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] inst;
    logic            valid;
  } ifid_t;

  // Bubble bundle for a given NOP encoding.
  function automatic ifid_t nop_bundle(input logic [XLEN-1:0] nop);
    ifid_t b;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.inst     = nop;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n : clock, async active-low reset (resets to the bubble bundle)
//   load       : capture d this edge
//   flush      : replace contents with the bubble bundle (beats hold/load)
//   hold       : keep contents (beats load)
//   d / q      : incoming / registered IF/ID bundle
module if_id_reg
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] NOP_VAL = NOP_INST
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  flush,
  input  logic  hold,
  input  ifid_t d,
  output ifid_t q
);

  // Priority: flush > hold > load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= nop_bundle(NOP_VAL);
    end else if (flush) begin
      q <= nop_bundle(NOP_VAL);
    end else if (load && !hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID capture,
// fetch counter and sticky misaligned-redirect flag.
//   clk, rst_n      : clock, async active-low reset
//   stall           : hold PC, IF/ID and counter
//   redirect        : taken branch/jump from EX; flush IF/ID, load redirect_pc
//   redirect_pc     : redirect target (low two bits dropped, flagged if set)
//   imem_addr       : fetch address, straight from the PC register
//   imem_inst       : instruction returned combinationally by memory
//   ifid_*          : IF/ID register contents
//   fetch_count     : saturating count of instructions accepted into IF/ID
//   misalign_err    : sticky, set by a redirect with target[1:0] != 0
module if_stage #(
  parameter logic [31:0]  RESET_PC = rv_pipe_pkg::RESET_PC,
  parameter logic [31:0]  NOP_INST = rv_pipe_pkg::NOP_INST,
  parameter int unsigned  CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_inst,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_pc_plus4,
  output logic [31:0]      ifid_inst,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] fetch_count,
  output logic             misalign_err
);

  import rv_pipe_pkg::*;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        advance;
  ifid_t       ifid_d;
  ifid_t       ifid_q;

  assign pc_plus4  = pc + 32'd4;  // wraps modulo 2^32
  assign advance   = !redirect && !stall;
  assign imem_addr = pc;

  // PC register: redirect beats stall beats advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc & PC_ALIGN_MASK;
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

  // Counts accepted fetches; saturates at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (advance && (fetch_count != {CNT_W{1'b1}})) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  always_comb begin
    ifid_d          = nop_bundle(NOP_INST);
    ifid_d.pc       = pc;
    ifid_d.pc_plus4 = pc_plus4;
    ifid_d.inst     = imem_inst;
    ifid_d.valid    = 1'b1;
  end

  if_id_reg #(
    .NOP_VAL (NOP_INST)
  ) u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b1),
    .flush (redirect),
    .hold  (stall),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_inst     = ifid_q.inst;
  assign ifid_valid    = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_inst;
  logic        ifid_valid;
  logic [31:0] fetch_count;
  logic        misalign_err;

  // Second instance with a 3-bit counter to exercise saturation.
  logic [31:0] imem_addr2;
  logic [31:0] imem_inst2;
  logic [31:0] ifid_pc2;
  logic [31:0] ifid_pc_plus4_2;
  logic [31:0] ifid_inst2;
  logic        ifid_valid2;
  logic [2:0]  fetch_count2;
  logic        misalign_err2;

  logic [31:0] mem [64];

  int tests;
  int fails;

  assign imem_inst  = mem[imem_addr[7:2]];
  assign imem_inst2 = mem[imem_addr2[7:2]];

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_inst     (ifid_inst),
    .ifid_valid    (ifid_valid),
    .fetch_count   (fetch_count),
    .misalign_err  (misalign_err)
  );

  if_stage #(.CNT_W(3)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr2),
    .imem_inst     (imem_inst2),
    .ifid_pc       (ifid_pc2),
    .ifid_pc_plus4 (ifid_pc_plus4_2),
    .ifid_inst     (ifid_inst2),
    .ifid_valid    (ifid_valid2),
    .fetch_count   (fetch_count2),
    .misalign_err  (misalign_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] plus4;
    logic [31:0] inst;
    logic        valid;
    logic [31:0] cnt;
    logic        mis;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] addr, input logic [31:0] ipc,
                           input logic [31:0] plus4, input logic [31:0] inst, input logic valid,
                           input logic [31:0] cnt, input logic mis);
    check({tag, ".imem_addr"},     imem_addr,      addr);
    check({tag, ".ifid_pc"},       ifid_pc,        ipc);
    check({tag, ".ifid_pc_plus4"}, ifid_pc_plus4,  plus4);
    check({tag, ".ifid_inst"},     ifid_inst,      inst);
    check({tag, ".ifid_valid"},    32'(ifid_valid), 32'(valid));
    check({tag, ".fetch_count"},   fetch_count,    cnt);
    check({tag, ".misalign_err"},  32'(misalign_err), 32'(mis));
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0] = 32'h0000_2083;
    mem[1] = 32'h0040_2103;

    //          stall redir rpc           addr          ipc           plus4         inst          v     cnt mis
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h4,        32'h0000_2083, 1'b1, 1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h8,        32'h4,        32'h8,        32'h0040_2103, 1'b1, 2, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'hC,        32'h8,        32'hC,        32'hA500_0002, 1'b1, 3, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'hC,        32'h8,        32'hC,        32'hA500_0002, 1'b1, 3, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'hC,        32'h8,        32'hC,        32'hA500_0002, 1'b1, 3, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'hC,        32'h8,        32'hC,        32'hA500_0002, 1'b1, 3, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h10,       32'hC,        32'h10,       32'hA500_0003, 1'b1, 4, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h18,       32'h18,       32'h0,        32'h0,        NOP,           1'b0, 4, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h1C,       32'h18,       32'h1C,       32'hA500_0006, 1'b1, 5, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h22,       32'h20,       32'h0,        32'h0,        NOP,           1'b0, 5, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h40,       32'h40,       32'h0,        32'h0,        NOP,           1'b0, 5, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h44,       32'h40,       32'h44,       32'hA500_0010, 1'b1, 6, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,      32'h0,        NOP,           1'b0, 6, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0,       32'hA500_003F, 1'b1, 7, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0,       32'hA500_003F, 1'b1, 7, 1'b1};

    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #12;
    check_all("reset", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      stall       = vecs[i].stall;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].ipc, vecs[i].plus4,
                vecs[i].inst, vecs[i].valid, vecs[i].cnt, vecs[i].mis);
      check($sformatf("vec%0d.sat_count", i), 32'(fetch_count2), vecs[i].cnt);
    end

    // Asynchronous reset between edges while stalled.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 32'h0, 1'b0);
    stall    = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release fetches word 0.
    @(posedge clk);
    #1;
    check_all("post_rst", 32'h4, 32'h0, 32'h4, 32'h0000_2083, 1'b1, 32'h1, 1'b0);

    // Ten more fetches: the 3-bit counter saturates at 7.
    repeat (10) @(posedge clk);
    #1;
    check("run.fetch_count", fetch_count, 32'd11);
    check("run.sat_count", 32'(fetch_count2), 32'd7);
    check("run.imem_addr", imem_addr, 32'd44);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
